// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle instruction sequencer (IDLE/DECODE/EXEC/MEM/WB).
// Accepts one instruction over valid/ready, issues registered ALU op and
// time-qualified control strobes, runs a memory handshake with timeout and
// resolves branches from the datapath compare result.
//
// Opcode map (instr[4:1], itype = instr[0] = 0):
//   0000 li   0001 load 0010 store 0011 add  0100 sub  0101 xor 0110 or
//   0111 and  1000 jump 1001 beq  1010 blt  1011 bgt  1100 shl 1101 shr
//   1110/1111 illegal
// itype = 1 is a put; the opcode field is then ignored.
module multicycle_control #(
  parameter int IW          = 9,
  parameter int ALUW        = 4,
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [IW-1:0]   instr,
  output logic            instr_ready,
  input  logic            mem_ack,
  input  logic            branch_taken,
  output logic [ALUW-1:0] ALUOp,
  output logic            immtoRegFlag,
  output logic            memToRegFlag,
  output logic            regWriteFlag,
  output logic            memWriteFlag,
  output logic            mem_req,
  output logic            branchFlag,
  output logic            putFlag,
  output logic            done,
  output logic            err_illegal,
  output logic            err_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;

  // All registered control outputs travel together; everything defaults to 0
  // each cycle so strobes are naturally single-cycle.
  typedef struct packed {
    logic imm;
    logic memto;
    logic regwr;
    logic memwr;
    logic req;
    logic br;
    logic put;
    logic done;
    logic ill;
    logic tmo;
  } ctl_t;

  localparam bit               TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [3:0]       ALU_DEF  = 4'b0111;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic              itype_q, itype_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [ALUW-1:0]   alu_q, alu_d;
  ctl_t              ctl_q, ctl_d;

  // Bits above the opcode carry no meaning for control.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr;

  // Instruction classification from the latched word.
  logic is_li, is_load, is_store, is_jump, is_branch, is_illegal, writes_reg, taken;
  logic [3:0] alu_code;

  // Classify the latched instruction and look up its ALU code.
  always_comb begin
    is_li      = !itype_q && (op_q == 4'b0000);
    is_load    = !itype_q && (op_q == 4'b0001);
    is_store   = !itype_q && (op_q == 4'b0010);
    is_jump    = !itype_q && (op_q == 4'b1000);
    is_branch  = !itype_q && (op_q inside {4'b1001, 4'b1010, 4'b1011});
    is_illegal = !itype_q && (op_q[3:1] == 3'b111);
    writes_reg = !itype_q && (op_q inside {4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
                                           4'b0110, 4'b0111, 4'b1100, 4'b1101});
    taken      = is_jump || (is_branch && branch_taken);
    alu_code   = ALU_DEF;
    if (!itype_q) begin
      case (op_q)
        4'b0011: alu_code = 4'b0101;  // add
        4'b0100: alu_code = 4'b0110;  // sub
        4'b0101: alu_code = 4'b0001;  // xor
        4'b0110: alu_code = 4'b0010;  // or
        4'b0111: alu_code = 4'b0000;  // and
        4'b1001: alu_code = 4'b1010;  // beq
        4'b1010: alu_code = 4'b1000;  // blt
        4'b1011: alu_code = 4'b1001;  // bgt
        4'b1100: alu_code = 4'b0011;  // shl
        4'b1101: alu_code = 4'b0100;  // shr
        default: alu_code = ALU_DEF;
      endcase
    end
  end

  // Next-state and next-output logic; outputs are registered so each strobe is
  // computed one cycle ahead, from the state being entered.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    itype_d = itype_q;
    cnt_d   = cnt_q;
    alu_d   = alu_q;
    ctl_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = instr[4:1];
          itype_d = instr[0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_d = ALUW'(alu_code);
        if (is_illegal) begin
          ctl_d.ill  = 1'b1;
          ctl_d.done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d     = S_MEM;
          cnt_d       = '0;
          ctl_d.req   = 1'b1;
          ctl_d.memwr = is_store;
        end else begin
          // The branch decision is registered straight into branchFlag for WB.
          state_d  = S_WB;
          ctl_d.br = taken;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          // Ack beats a coincident timeout.
          if (is_load) begin
            state_d = S_WB;
          end else begin
            ctl_d.done = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          ctl_d.tmo  = 1'b1;
          ctl_d.done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d       = cnt_q + TMO_W'(1);
          ctl_d.req   = 1'b1;
          ctl_d.memwr = is_store;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_WB) begin
      ctl_d.done  = 1'b1;
      ctl_d.regwr = writes_reg;
      ctl_d.imm   = is_li;
      ctl_d.memto = is_load;
      ctl_d.put   = itype_q;
    end
  end

  // State, latched instruction, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      itype_q <= 1'b0;
      cnt_q   <= '0;
      alu_q   <= ALUW'(ALU_DEF);
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      itype_q <= itype_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
      ctl_q   <= ctl_d;
    end
  end

  assign instr_ready  = (state_q == S_IDLE) && !reset;
  assign ALUOp        = alu_q;
  assign immtoRegFlag = ctl_q.imm;
  assign memToRegFlag = ctl_q.memto;
  assign regWriteFlag = ctl_q.regwr;
  assign memWriteFlag = ctl_q.memwr;
  assign mem_req      = ctl_q.req;
  assign branchFlag   = ctl_q.br;
  assign putFlag      = ctl_q.put;
  assign done         = ctl_q.done;
  assign err_illegal  = ctl_q.ill;
  assign err_timeout  = ctl_q.tmo;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: table of instruction vectors with
// hand-computed per-transaction expectations, plus reset corner sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic       mem_ack;
  logic       branch_taken;
  logic [3:0] ALUOp;
  logic       immtoRegFlag, memToRegFlag, regWriteFlag, memWriteFlag, mem_req;
  logic       branchFlag, putFlag, done, err_illegal, err_timeout;

  int n_vec = 0;
  int n_err = 0;

  multicycle_control #(.IW(9), .ALUW(4), .TMO_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .mem_ack(mem_ack), .branch_taken(branch_taken),
    .ALUOp(ALUOp), .immtoRegFlag(immtoRegFlag), .memToRegFlag(memToRegFlag),
    .regWriteFlag(regWriteFlag), .memWriteFlag(memWriteFlag), .mem_req(mem_req),
    .branchFlag(branchFlag), .putFlag(putFlag), .done(done),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // One transaction: cycle 0 is the handshake cycle. Counts are numbers of
  // cycles the strobe was high; done_c/ready_c are the first cycles seen.
  typedef struct {
    logic [8:0] instr;
    logic       bt;
    int         ack_k;   // MEM cycle in which mem_ack is driven, -1 = never
    logic [3:0] alu;     // ALUOp seen in cycle 2
    int done_c, ready_c, regwr, imm, memto, br, put, ill, tmo, memreq, memwr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] mk(input logic [3:0] op, input logic it);
    return {4'b0000, op, it};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int strobes();
    return int'(regWriteFlag) + int'(immtoRegFlag) + int'(memToRegFlag) + int'(branchFlag)
         + int'(putFlag) + int'(done) + int'(err_illegal) + int'(err_timeout)
         + int'(mem_req) + int'(memWriteFlag);
  endfunction

  // Called mid-cycle with the DUT in IDLE; returns at the negedge of the
  // first cycle in which instr_ready is high again.
  task automatic apply(input int idx, input vec_t v);
    int done_c = -1, ready_c = -1, n_done = 0, bad = 0;
    int n_rw = 0, n_imm = 0, n_mt = 0, n_br = 0, n_put = 0, n_ill = 0, n_to = 0, n_rq = 0, n_mw = 0;
    logic [3:0] alu2 = 4'hx;
    instr_valid  = 1'b1;
    instr        = v.instr;
    branch_taken = v.bt;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = '0;
    for (int c = 1; c <= 40; c++) begin
      mem_ack = (v.ack_k >= 0) && (c == 3 + v.ack_k);
      @(negedge clk);
      if (c == 2) alu2 = ALUOp;
      if (done) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      n_rw  += int'(regWriteFlag);
      n_imm += int'(immtoRegFlag);
      n_mt  += int'(memToRegFlag);
      n_br  += int'(branchFlag);
      n_put += int'(putFlag);
      n_ill += int'(err_illegal);
      n_to  += int'(err_timeout);
      n_rq  += int'(mem_req);
      n_mw  += int'(memWriteFlag);
      if ((regWriteFlag || immtoRegFlag || memToRegFlag || branchFlag || putFlag ||
           err_illegal || err_timeout) && !done) bad++;
      if (memWriteFlag && !mem_req) bad++;
      if (instr_ready) begin
        ready_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    chk($sformatf("v%0d ALUOp", idx), int'(alu2), int'(v.alu));
    chk($sformatf("v%0d done cycle", idx), done_c, v.done_c);
    chk($sformatf("v%0d done count", idx), n_done, 1);
    chk($sformatf("v%0d ready cycle", idx), ready_c, v.ready_c);
    chk($sformatf("v%0d regWrite", idx), n_rw, v.regwr);
    chk($sformatf("v%0d immtoReg", idx), n_imm, v.imm);
    chk($sformatf("v%0d memToReg", idx), n_mt, v.memto);
    chk($sformatf("v%0d branch", idx), n_br, v.br);
    chk($sformatf("v%0d put", idx), n_put, v.put);
    chk($sformatf("v%0d err_illegal", idx), n_ill, v.ill);
    chk($sformatf("v%0d err_timeout", idx), n_to, v.tmo);
    chk($sformatf("v%0d mem_req cycles", idx), n_rq, v.memreq);
    chk($sformatf("v%0d memWrite cycles", idx), n_mw, v.memwr);
    chk($sformatf("v%0d strobe outside done", idx), bad, 0);
  endtask

  initial begin
    int quiet;
    vec_t xv;
    reset        = 1'b1;
    instr_valid  = 1'b0;
    instr        = '0;
    mem_ack      = 1'b0;
    branch_taken = 1'b0;

    //                  instr                bt ack alu      dn rdy rw im mt br pu il to rq mw
    vecs.push_back('{mk(4'b0011, 1'b0),     0, -1, 4'b0101, 3, 4,  1, 0, 0, 0, 0, 0, 0, 0, 0});  // add
    vecs.push_back('{mk(4'b0001, 1'b0),     0,  2, 4'b0111, 6, 7,  1, 0, 1, 0, 0, 0, 0, 3, 0});  // load, ack k=2
    vecs.push_back('{mk(4'b0010, 1'b0),     0, -1, 4'b0111, 18, 18, 0, 0, 0, 0, 0, 0, 1, 15, 15}); // store timeout
    vecs.push_back('{mk(4'b1001, 1'b0),     1, -1, 4'b1010, 3, 4,  0, 0, 0, 1, 0, 0, 0, 0, 0});  // beq taken
    vecs.push_back('{mk(4'b1001, 1'b0),     0, -1, 4'b1010, 3, 4,  0, 0, 0, 0, 0, 0, 0, 0, 0});  // beq not taken
    vecs.push_back('{mk(4'b1110, 1'b0),     0, -1, 4'b0111, 2, 2,  0, 0, 0, 0, 0, 1, 0, 0, 0});  // illegal 1110
    vecs.push_back('{mk(4'b1111, 1'b0),     0, -1, 4'b0111, 2, 2,  0, 0, 0, 0, 0, 1, 0, 0, 0});  // illegal 1111
    vecs.push_back('{mk(4'b0000, 1'b1),     0, -1, 4'b0111, 3, 4,  0, 0, 0, 0, 1, 0, 0, 0, 0});  // put
    vecs.push_back('{mk(4'b1111, 1'b1),     1, -1, 4'b0111, 3, 4,  0, 0, 0, 0, 1, 0, 0, 0, 0});  // put, not illegal
    vecs.push_back('{mk(4'b0010, 1'b0),     0,  0, 4'b0111, 4, 4,  0, 0, 0, 0, 0, 0, 0, 1, 1});  // store ack k=0
    vecs.push_back('{mk(4'b0001, 1'b0),     0,  0, 4'b0111, 4, 5,  1, 0, 1, 0, 0, 0, 0, 1, 0});  // load ack k=0
    vecs.push_back('{mk(4'b0000, 1'b0),     0, -1, 4'b0111, 3, 4,  1, 1, 0, 0, 0, 0, 0, 0, 0});  // li
    vecs.push_back('{mk(4'b1000, 1'b0),     0, -1, 4'b0111, 3, 4,  0, 0, 0, 1, 0, 0, 0, 0, 0});  // jump
    vecs.push_back('{mk(4'b1010, 1'b0),     1, -1, 4'b1000, 3, 4,  0, 0, 0, 1, 0, 0, 0, 0, 0});  // blt taken
    vecs.push_back('{mk(4'b1011, 1'b0),     0, -1, 4'b1001, 3, 4,  0, 0, 0, 0, 0, 0, 0, 0, 0});  // bgt not taken
    vecs.push_back('{mk(4'b1100, 1'b0),     0, -1, 4'b0011, 3, 4,  1, 0, 0, 0, 0, 0, 0, 0, 0});  // shl
    vecs.push_back('{mk(4'b1101, 1'b0),     0, -1, 4'b0100, 3, 4,  1, 0, 0, 0, 0, 0, 0, 0, 0});  // shr
    vecs.push_back('{mk(4'b0101, 1'b0),     0, -1, 4'b0001, 3, 4,  1, 0, 0, 0, 0, 0, 0, 0, 0});  // xor
    vecs.push_back('{mk(4'b0100, 1'b0),     0, -1, 4'b0110, 3, 4,  1, 0, 0, 0, 0, 0, 0, 0, 0});  // sub
    vecs.push_back('{mk(4'b0110, 1'b0),     0, -1, 4'b0010, 3, 4,  1, 0, 0, 0, 0, 0, 0, 0, 0});  // or
    vecs.push_back('{mk(4'b0111, 1'b0),     0, -1, 4'b0000, 3, 4,  1, 0, 0, 0, 0, 0, 0, 0, 0});  // and
    vecs.push_back('{mk(4'b0001, 1'b0),     0, 14, 4'b0111, 18, 19, 1, 0, 1, 0, 0, 0, 0, 15, 0}); // load, ack on timeout cycle
    vecs.push_back('{mk(4'b0010, 1'b0),     0, 14, 4'b0111, 18, 18, 0, 0, 0, 0, 0, 0, 0, 15, 15}); // store, ack on timeout cycle
    vecs.push_back('{9'b1111_0011_0,        1,  0, 4'b0101, 3, 4,  1, 0, 0, 0, 0, 0, 0, 0, 0});  // add, high bits + stray ack
    vecs.push_back('{mk(4'b0001, 1'b1),     0, -1, 4'b0111, 3, 4,  0, 0, 0, 0, 1, 0, 0, 0, 0});  // put with load opcode

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    chk("reset ALUOp", int'(ALUOp), 7);
    chk("reset strobes", strobes(), 0);
    reset = 1'b0;
    #1;
    chk("ready after reset", int'(instr_ready), 1);

    // Table vectors, issued back to back.
    foreach (vecs[i]) apply(i, vecs[i]);

    // Reset during EXEC of an add: ALUOp returns to 0111 at once, no write follows.
    instr_valid = 1'b1;
    instr       = mk(4'b0011, 1'b0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre-reset ALUOp", int'(ALUOp), 5);
    reset = 1'b1;
    #1;
    chk("async ALUOp", int'(ALUOp), 7);
    chk("async strobes (exec)", strobes(), 0);
    @(negedge clk);
    reset = 1'b0;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      quiet += strobes();
    end
    chk("no strobe after exec reset", quiet, 0);

    // Reset during MEM of a load: mem_req drops asynchronously.
    instr_valid = 1'b1;
    instr       = mk(4'b0001, 1'b0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre-reset mem_req", int'(mem_req), 1);
    reset = 1'b1;
    #1;
    chk("async mem_req", int'(mem_req), 0);
    chk("async strobes (mem)", strobes(), 0);
    chk("async ALUOp (mem)", int'(ALUOp), 7);
    @(negedge clk);
    reset = 1'b0;
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      quiet += strobes();
    end
    chk("no strobe after mem reset", quiet, 0);
    chk("ready after mem reset", int'(instr_ready), 1);

    // xor after the abort completes normally.
    xv = '{mk(4'b0101, 1'b0), 0, -1, 4'b0001, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    apply(100, xv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised, multi-cycle successor to the single-cycle control decoder. It accepts one instruction at a time over a valid/ready handshake and sequences it through DECODE, EXEC, optional MEM and WB states. It emits the same control flags and ALU op codes as the combinational decoder, but time-qualified per state. It also adds a memory request/acknowledge handshake with timeout, branch resolution from the datapath compare result, and illegal-opcode detection. It sits between the fetch stage and the datapath of the multi-cycle core.

## Interface
- IW, 9: instruction width; must be ≥ 5. Bit 0 is itype; bits [4:1] are the opcode; bits above 4 are ignored.
- ALUW, 4: ALUOp width; must be ≥ 4. Codes are zero-extended.
- TMO_W, 4: width of the memory-timeout counter.
- MEM_TIMEOUT, 15: number of MEM cycles without `mem_ack` before abort. Must be ≤ 2^TMO_W − 1. A value of 0 disables the timeout.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  an instruction is offered.
- instr  in  IW  instruction word; sampled on handshake.
- instr_ready  out  1  high only in IDLE.
- mem_ack  in  1  memory completed the current request.
- branch_taken  in  1  datapath compare result; sampled on the last EXEC cycle.
- ALUOp  out  ALUW  registered ALU operation.
- immtoRegFlag, memToRegFlag  out  1 each  write-back source select.
- regWriteFlag  out  1  register-file write enable; one-cycle strobe in WB.
- memWriteFlag  out  1  store enable; high with `mem_req` for stores.
- mem_req  out  1  memory request; held in MEM until ack or timeout.
- branchFlag  out  1  PC-redirect strobe in WB.
- putFlag  out  1  put-type instruction; strobe in WB.
- done  out  1  one-cycle pulse when an instruction retires.
- err_illegal, err_timeout  out  1 each  one-cycle error pulses.

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB.
- IDLE: the handshake completes when `instr_valid && instr_ready`. The instruction is latched and the FSM goes to DECODE.
- DECODE (1 cycle): classify the latched instruction. Register ALUOp using the run-type opcode map:
  - add 0101, sub 0110, xor 0001, or 0010, and 0000
  - beq 1010, blt 1000, bgt 1001, shl 0011, shr 0100
  - every other opcode: 0111
- Next state after DECODE: go to EXEC. The exception is opcodes 1110 and 1111 with itype = 0, which pulse `err_illegal` and `done` and return to IDLE.
- EXEC (1 cycle): ALUOp is valid. Register `taken`:
  - jump (1000): taken = 1
  - beq/blt/bgt: taken = `branch_taken`
  - all others: taken = 0
  - Then go to MEM for load (0001) or store (0010); otherwise go to WB.
- MEM: `mem_req` = 1, and `memWriteFlag` = 1 for stores.
  - The timeout counter clears on entry and increments each MEM cycle.
  - On `mem_ack`: a load goes to WB; a store pulses `done` and goes to IDLE.
  - When the counter reaches MEM_TIMEOUT with no ack: pulse `err_timeout` and `done`, go to IDLE, no write-back.
  - If `mem_ack` arrives in the same cycle the timeout is reached, the ack wins.
- WB (1 cycle), then IDLE. `done` = 1 and `branchFlag` = taken.
  - `regWriteFlag` = 1 for load-immediate, load, ALU ops and shifts. It is 0 for store, jump, branches and put.
  - `immtoRegFlag` = 1 for load-immediate; `memToRegFlag` = 1 for load.
  - `putFlag` = 1 when itype = 1; the opcode is then ignored and no register write occurs.
- `instr_valid` is ignored outside IDLE.
- `mem_ack` is ignored outside MEM.
- `branch_taken` is ignored outside EXEC.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state = IDLE, ALUOp = 0111, all other outputs = 0.
  - `instr_ready` = 1 once reset is released.
- All outputs except `instr_ready` are registered. `instr_ready` is decoded from the state.
- Handshake in cycle 0; DECODE in cycle 1; EXEC in cycle 2.
- Non-memory instructions: WB in cycle 3, `instr_ready` again in cycle 4. Throughput is 1 per 4 cycles.
- Load: MEM starts in cycle 3. An ack seen in MEM cycle k (k = 0 is the first) puts WB at cycle 4 + k.
- Store: an ack in MEM cycle k gives `done` at cycle 4 + k, with no WB state.
- Timeout: `err_timeout` pulses on the cycle after the MEM_TIMEOUT-th MEM cycle without ack.
- Strobes (`regWriteFlag`, `branchFlag`, `putFlag`, `done`, error pulses) are high for exactly one cycle.
- ALUOp holds its value from DECODE until the next DECODE.
- Reset mid-instruction: abort immediately, with no pending strobe or write afterwards. `mem_req` drops asynchronously.
- Back-to-back instructions: a new handshake is possible in the cycle immediately after WB or the done cycle.

## Test plan
- Reset, then send add (instr = 9'b0_0011_0): ALUOp = 0101 from cycle 2; `regWriteFlag` and `done` pulse in cycle 3; `instr_ready` = 1 in cycle 4.
- Load (0001) with `mem_ack` on the third MEM cycle: `mem_req` high for 3 cycles; WB in cycle 6 with `memToRegFlag` = `regWriteFlag` = 1.
- Store (0010) with no ack, MEM_TIMEOUT = 15: `mem_req` and `memWriteFlag` high for 15 cycles; then one `err_timeout` + `done` pulse; no `regWriteFlag`.
- beq (1001):
  - with `branch_taken` = 1 in EXEC: `branchFlag` = 1 in WB, `regWriteFlag` = 0.
  - repeat with `branch_taken` = 0: `branchFlag` = 0.
- Opcode 1110 with itype = 0: `err_illegal` and `done` at cycle 2. Put (itype = 1): `putFlag` = 1, `regWriteFlag` = 0 in WB.
- Assert `reset` during MEM of a load: all outputs return to reset values immediately. Then send xor: it completes normally with ALUOp = 0001.
